// File: rtl/writeback_stage_pkg.sv
// writeback_stage_pkg
//   Shared definitions for the writeback stage.
//   - Data-cache store FSM state encodings.
//   - ZF position in EFLAGS and the ECX register id.
//   - Datasize codes.
//   - Control-store bit positions of the WB load fields.
//   - A helper that decides whether a uop writes the full ECX register.
package writeback_stage_pkg;

  localparam int          ZF_BIT = 6;
  localparam logic [2:0]  ECX_ID = 3'd1;

  localparam logic [1:0]  SIZE_BYTE  = 2'b00;
  localparam logic [1:0]  SIZE_WORD  = 2'b01;
  localparam logic [1:0]  SIZE_DWORD = 2'b10;

  // Positions of the writeback load bits inside the uop control word
  localparam int CS_LD_GPR3_WB  = 0;
  localparam int CS_LD_SEG_WB   = 1;
  localparam int CS_LD_MM_WB    = 2;
  localparam int CS_LD_FLAGS_WB = 3;
  localparam int CS_LD_EIP_WB   = 4;
  localparam int CS_WB_FIELDS   = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } store_state_e;

  // A dword write of DR1 to ECX replaces the architectural count
  function automatic logic isEcxDwordWrite(input logic       ldGpr1,
                                           input logic [2:0] dr1,
                                           input logic [1:0] size);
    return ldGpr1 && (dr1 == ECX_ID) && (size == SIZE_DWORD);
  endfunction

endpackage

// File: rtl/wb_dcache_store_fsm.sv
// wb_dcache_store_fsm
//   Sequences a single data-cache store for the uop held in the WB latch.
//   clk_i    : clock, rising edge
//   rst_ni   : asynchronous active-low reset
//   valid_i  : WB latch holds a valid uop
//   store_i  : that uop writes the data cache
//   ack_i    : cache accepted the store this cycle
//   req_o    : store request to the data cache
//   stall_o  : WB cannot retire this cycle
module wb_dcache_store_fsm
  import writeback_stage_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic valid_i,
  input  logic store_i,
  input  logic ack_i,
  output logic req_o,
  output logic stall_o
);

  store_state_e state_q, state_d;

  // State register; reset drops any outstanding request immediately
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and request/stall generation.
  // An ack seen in IDLE retires the store in that same cycle. An ack seen in
  // WAIT only moves to DONE, and the uop retires in DONE. The stall is
  // therefore held through the WAIT ack cycle, so the uop commits exactly once.
  // DONE never re-raises the request, so a store is never reissued.
  always_comb begin
    state_d = state_q;
    req_o   = 1'b0;
    stall_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid_i && store_i) begin
          req_o = 1'b1;
          if (!ack_i) begin
            stall_o = 1'b1;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        req_o   = 1'b1;
        stall_o = valid_i && store_i;
        if (ack_i) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage
//   Receiving end of the EX->WB pipeline interface.
//   It holds the WB latch and commits results to the GPR, segment, MM, EIP and
//   EFLAGS state. It sequences data-cache stores, stalling EX while a store is
//   outstanding, and terminates REPNE loops. It also forwards the architectural
//   flags and count back to EX.
//   Inputs  : CLK, CLR (async active-low), WB_ld_latches, WB_*_next latch fields,
//             dcache_wr_ack
//   Outputs : WB_stall, wb_repne_terminate_all, flags/count_dataforwarded,
//             gpr_we/addr/data/size, seg_we, mm_we, mm_data,
//             dcache_wr_req/addr/data/size, eip_we, eip_out, cs_out
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int DW  = 32,
  parameter int MMW = 64,
  parameter int CSW = 128
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              WB_ld_latches,
  input  logic              WB_V_next,
  input  logic [DW-1:0]     WB_NEIP_next,
  input  logic [15:0]       WB_NCS_next,
  input  logic [CSW-1:0]    WB_CONTROL_STORE_next,
  input  logic [1:0]        WB_d2_datasize_all_next,
  input  logic              WB_ex_ld_gpr1_wb_next,
  input  logic              WB_ex_ld_gpr2_wb_next,
  input  logic              WB_ex_dcache_write_wb_next,
  input  logic              WB_d2_repne_wb_next,
  input  logic [DW-1:0]     WB_RESULT_A_next,
  input  logic [DW-1:0]     WB_RESULT_B_next,
  input  logic [DW-1:0]     WB_RESULT_C_next,
  input  logic [DW-1:0]     WB_FLAGS_next,
  input  logic [MMW-1:0]    WB_RESULT_MM_next,
  input  logic [2:0]        WB_DR1_next,
  input  logic [2:0]        WB_DR2_next,
  input  logic [2:0]        WB_DR3_next,
  input  logic [DW-1:0]     WB_ADDRESS_next,
  input  logic              dcache_wr_ack,
  output logic              WB_stall,
  output logic              wb_repne_terminate_all,
  output logic [DW-1:0]     flags_dataforwarded,
  output logic [DW-1:0]     count_dataforwarded,
  output logic [2:0]        gpr_we,
  output logic [8:0]        gpr_addr,
  output logic [3*DW-1:0]   gpr_data,
  output logic [1:0]        gpr_size,
  output logic              seg_we,
  output logic              mm_we,
  output logic [MMW-1:0]    mm_data,
  output logic              dcache_wr_req,
  output logic [DW-1:0]     dcache_wr_addr,
  output logic [DW-1:0]     dcache_wr_data,
  output logic [1:0]        dcache_wr_size,
  output logic              eip_we,
  output logic [DW-1:0]     eip_out,
  output logic [15:0]       cs_out
);

  localparam logic [DW-1:0] EFLAGS_RESET = {{(DW-2){1'b0}}, 2'b10};

  logic             v_q;
  logic [CS_WB_FIELDS-1:0] cs_q;
  logic [DW-1:0]    neip_q;
  logic [15:0]      ncs_q;
  logic [1:0]       size_q;
  logic             ldGpr1_q, ldGpr2_q, store_q, repne_q;
  logic [DW-1:0]    a_q, b_q, c_q, flags_q, addr_q;
  logic [MMW-1:0]   mm_q;
  logic [2:0]       dr1_q, dr2_q, dr3_q;
  logic [DW-1:0]    eflags_q, count_q;

  logic commit;
  logic term;
  logic ecxWrite;
  logic unusedCsBits;

  // Only the WB load fields of the control word matter in this stage
  assign unusedCsBits = ^WB_CONTROL_STORE_next[CSW-1:CS_WB_FIELDS];

  assign commit   = v_q && !WB_stall;
  assign term     = commit && repne_q && ((c_q == '0) || flags_q[ZF_BIT]);
  assign ecxWrite = isEcxDwordWrite(ldGpr1_q, dr1_q, size_q);

  // WB latch. A uop loaded while REPNE terminates is on the wrong path, so
  // its valid bit is squashed. A retired uop that is not replaced drops valid,
  // which keeps it from committing (or storing) a second time.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      v_q      <= 1'b0;
      cs_q     <= '0;
      neip_q   <= '0;
      ncs_q    <= '0;
      size_q   <= '0;
      ldGpr1_q <= 1'b0;
      ldGpr2_q <= 1'b0;
      store_q  <= 1'b0;
      repne_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      flags_q  <= '0;
      mm_q     <= '0;
      dr1_q    <= '0;
      dr2_q    <= '0;
      dr3_q    <= '0;
      addr_q   <= '0;
    end else if (WB_ld_latches && !WB_stall) begin
      v_q      <= WB_V_next && !term;
      cs_q     <= WB_CONTROL_STORE_next[CS_WB_FIELDS-1:0];
      neip_q   <= WB_NEIP_next;
      ncs_q    <= WB_NCS_next;
      size_q   <= WB_d2_datasize_all_next;
      ldGpr1_q <= WB_ex_ld_gpr1_wb_next;
      ldGpr2_q <= WB_ex_ld_gpr2_wb_next;
      store_q  <= WB_ex_dcache_write_wb_next;
      repne_q  <= WB_d2_repne_wb_next;
      a_q      <= WB_RESULT_A_next;
      b_q      <= WB_RESULT_B_next;
      c_q      <= WB_RESULT_C_next;
      flags_q  <= WB_FLAGS_next;
      mm_q     <= WB_RESULT_MM_next;
      dr1_q    <= WB_DR1_next;
      dr2_q    <= WB_DR2_next;
      dr3_q    <= WB_DR3_next;
      addr_q   <= WB_ADDRESS_next;
    end else if (commit) begin
      v_q      <= 1'b0;
    end
  end

  // Architectural EFLAGS and count; a REPNE count update wins over an ECX write
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      eflags_q <= EFLAGS_RESET;
      count_q  <= '0;
    end else if (commit) begin
      if (cs_q[CS_LD_FLAGS_WB]) begin
        eflags_q <= flags_q;
      end
      if (repne_q) begin
        count_q <= c_q;
      end else if (ecxWrite) begin
        count_q <= a_q;
      end
    end
  end

  wb_dcache_store_fsm u_store_fsm (
    .clk_i   (CLK),
    .rst_ni  (CLR),
    .valid_i (v_q),
    .store_i (store_q),
    .ack_i   (dcache_wr_ack),
    .req_o   (dcache_wr_req),
    .stall_o (WB_stall)
  );

  assign wb_repne_terminate_all = term;

  // Forwarding bypasses the pending (valid) uop before it is committed
  assign flags_dataforwarded = (v_q && cs_q[CS_LD_FLAGS_WB]) ? flags_q : eflags_q;
  assign count_dataforwarded = (v_q && repne_q)  ? c_q :
                               (v_q && ecxWrite) ? a_q : count_q;

  assign gpr_we   = {cs_q[CS_LD_GPR3_WB], ldGpr2_q, ldGpr1_q} & {3{commit}};
  assign gpr_addr = {dr3_q, dr2_q, dr1_q};
  assign gpr_data = {c_q, b_q, a_q};
  assign gpr_size = size_q;
  assign seg_we   = cs_q[CS_LD_SEG_WB] && commit;
  assign mm_we    = cs_q[CS_LD_MM_WB] && commit;
  assign mm_data  = mm_q;
  assign eip_we   = cs_q[CS_LD_EIP_WB] && commit;
  assign eip_out  = neip_q;
  assign cs_out   = ncs_q;

  assign dcache_wr_addr = addr_q;
  assign dcache_wr_data = a_q;
  assign dcache_wr_size = size_q;

endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage
//   Self-checking bench for writeback_stage.
//   Every valid uop sets the EIP load bit, so eip_we marks each commit.
//   Expected commit results are queued when a uop is driven and are compared
//   when eip_we is seen. Store sequencing and reset behaviour are checked
//   directly in the main flow.
module tb_writeback_stage;
  import writeback_stage_pkg::*;

  localparam int DW  = 32;
  localparam int MMW = 64;
  localparam int CSW = 128;

  logic            CLK;
  logic            CLR;
  logic            WB_ld_latches;
  logic            WB_V_next;
  logic [DW-1:0]   WB_NEIP_next;
  logic [15:0]     WB_NCS_next;
  logic [CSW-1:0]  WB_CONTROL_STORE_next;
  logic [1:0]      WB_d2_datasize_all_next;
  logic            WB_ex_ld_gpr1_wb_next;
  logic            WB_ex_ld_gpr2_wb_next;
  logic            WB_ex_dcache_write_wb_next;
  logic            WB_d2_repne_wb_next;
  logic [DW-1:0]   WB_RESULT_A_next, WB_RESULT_B_next, WB_RESULT_C_next;
  logic [DW-1:0]   WB_FLAGS_next;
  logic [MMW-1:0]  WB_RESULT_MM_next;
  logic [2:0]      WB_DR1_next, WB_DR2_next, WB_DR3_next;
  logic [DW-1:0]   WB_ADDRESS_next;
  logic            dcache_wr_ack;
  logic            WB_stall;
  logic            wb_repne_terminate_all;
  logic [DW-1:0]   flags_dataforwarded, count_dataforwarded;
  logic [2:0]      gpr_we;
  logic [8:0]      gpr_addr;
  logic [3*DW-1:0] gpr_data;
  logic [1:0]      gpr_size;
  logic            seg_we, mm_we;
  logic [MMW-1:0]  mm_data;
  logic            dcache_wr_req;
  logic [DW-1:0]   dcache_wr_addr, dcache_wr_data;
  logic [1:0]      dcache_wr_size;
  logic            eip_we;
  logic [DW-1:0]   eip_out;
  logic [15:0]     cs_out;

  writeback_stage #(.DW(DW), .MMW(MMW), .CSW(CSW)) dut (
    .CLK(CLK), .CLR(CLR), .WB_ld_latches(WB_ld_latches),
    .WB_V_next(WB_V_next), .WB_NEIP_next(WB_NEIP_next), .WB_NCS_next(WB_NCS_next),
    .WB_CONTROL_STORE_next(WB_CONTROL_STORE_next),
    .WB_d2_datasize_all_next(WB_d2_datasize_all_next),
    .WB_ex_ld_gpr1_wb_next(WB_ex_ld_gpr1_wb_next),
    .WB_ex_ld_gpr2_wb_next(WB_ex_ld_gpr2_wb_next),
    .WB_ex_dcache_write_wb_next(WB_ex_dcache_write_wb_next),
    .WB_d2_repne_wb_next(WB_d2_repne_wb_next),
    .WB_RESULT_A_next(WB_RESULT_A_next), .WB_RESULT_B_next(WB_RESULT_B_next),
    .WB_RESULT_C_next(WB_RESULT_C_next), .WB_FLAGS_next(WB_FLAGS_next),
    .WB_RESULT_MM_next(WB_RESULT_MM_next),
    .WB_DR1_next(WB_DR1_next), .WB_DR2_next(WB_DR2_next), .WB_DR3_next(WB_DR3_next),
    .WB_ADDRESS_next(WB_ADDRESS_next), .dcache_wr_ack(dcache_wr_ack),
    .WB_stall(WB_stall), .wb_repne_terminate_all(wb_repne_terminate_all),
    .flags_dataforwarded(flags_dataforwarded), .count_dataforwarded(count_dataforwarded),
    .gpr_we(gpr_we), .gpr_addr(gpr_addr), .gpr_data(gpr_data), .gpr_size(gpr_size),
    .seg_we(seg_we), .mm_we(mm_we), .mm_data(mm_data),
    .dcache_wr_req(dcache_wr_req), .dcache_wr_addr(dcache_wr_addr),
    .dcache_wr_data(dcache_wr_data), .dcache_wr_size(dcache_wr_size),
    .eip_we(eip_we), .eip_out(eip_out), .cs_out(cs_out)
  );

  typedef struct packed {
    logic [2:0]  gprWe;
    logic [2:0]  dr1;
    logic [31:0] resA;
    logic [31:0] eip;
    logic        term;
    logic [31:0] cnt;
    logic [31:0] flg;
  } expect_t;

  expect_t     scoreQ[$];
  expect_t     mon;
  int          total = 0;
  int          bad   = 0;
  logic [31:0] modelFlags = 32'h2;
  logic [31:0] modelCount = 32'h0;
  logic        squashNext = 1'b0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Drive a bubble on every next-stage input
  task automatic clearInputs();
    WB_V_next = 1'b0;
    WB_NEIP_next = '0;
    WB_NCS_next = '0;
    WB_CONTROL_STORE_next = '0;
    WB_d2_datasize_all_next = SIZE_BYTE;
    WB_ex_ld_gpr1_wb_next = 1'b0;
    WB_ex_ld_gpr2_wb_next = 1'b0;
    WB_ex_dcache_write_wb_next = 1'b0;
    WB_d2_repne_wb_next = 1'b0;
    WB_RESULT_A_next = '0;
    WB_RESULT_B_next = '0;
    WB_RESULT_C_next = '0;
    WB_FLAGS_next = '0;
    WB_RESULT_MM_next = '0;
    WB_DR1_next = '0;
    WB_DR2_next = '0;
    WB_DR3_next = '0;
    WB_ADDRESS_next = '0;
  endtask

  task automatic idleCycles(input int n);
    clearInputs();
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
    squashNext = 1'b0;
  endtask

  // Load one non-store uop for one edge. Its commit result is queued unless
  // the previous uop terminates a REPNE loop, which squashes this one.
  task automatic applyStimulus(input logic ldG1, input logic ldG2, input logic ldG3,
                               input logic ldFlg, input logic repne,
                               input logic [2:0] dr1, input logic [1:0] size,
                               input logic [31:0] a, input logic [31:0] c,
                               input logic [31:0] flags, input logic [31:0] neip);
    expect_t e;
    clearInputs();
    WB_V_next = 1'b1;
    WB_CONTROL_STORE_next[CS_LD_EIP_WB]   = 1'b1;
    WB_CONTROL_STORE_next[CS_LD_GPR3_WB]  = ldG3;
    WB_CONTROL_STORE_next[CS_LD_FLAGS_WB] = ldFlg;
    WB_ex_ld_gpr1_wb_next = ldG1;
    WB_ex_ld_gpr2_wb_next = ldG2;
    WB_d2_repne_wb_next = repne;
    WB_DR1_next = dr1;
    WB_DR2_next = 3'd2;
    WB_DR3_next = 3'd3;
    WB_d2_datasize_all_next = size;
    WB_RESULT_A_next = a;
    WB_RESULT_B_next = a ^ 32'hFFFF;
    WB_RESULT_C_next = c;
    WB_FLAGS_next = flags;
    WB_NEIP_next = neip;
    if (squashNext) begin
      squashNext = 1'b0;
    end else begin
      e.gprWe = {ldG3, ldG2, ldG1};
      e.dr1   = dr1;
      e.resA  = a;
      e.eip   = neip;
      e.term  = repne && ((c == 32'h0) || flags[6]);
      e.flg   = ldFlg ? flags : modelFlags;
      e.cnt   = repne ? c : (ldG1 && dr1 == 3'd1 && size == 2'b10) ? a : modelCount;
      scoreQ.push_back(e);
      if (ldFlg) modelFlags = flags;
      modelCount = e.cnt;
      squashNext = e.term;
    end
    @(posedge CLK);
    #1;
    WB_V_next = 1'b0;
  endtask

  // Present a store uop (also loading EIP and SEG); queue its commit if asked
  task automatic driveStore(input logic [31:0] addr, input logic [31:0] a,
                            input logic [31:0] neip, input logic expectCommit);
    expect_t e;
    clearInputs();
    WB_V_next = 1'b1;
    WB_CONTROL_STORE_next[CS_LD_EIP_WB] = 1'b1;
    WB_CONTROL_STORE_next[CS_LD_SEG_WB] = 1'b1;
    WB_ex_dcache_write_wb_next = 1'b1;
    WB_d2_datasize_all_next = SIZE_WORD;
    WB_ADDRESS_next = addr;
    WB_RESULT_A_next = a;
    WB_NEIP_next = neip;
    if (expectCommit) begin
      e.gprWe = 3'b000;
      e.dr1   = 3'd0;
      e.resA  = a;
      e.eip   = neip;
      e.term  = 1'b0;
      e.flg   = modelFlags;
      e.cnt   = modelCount;
      scoreQ.push_back(e);
    end
    @(posedge CLK);
    #1;
    clearInputs();
  endtask

  // Commit monitor: pops the scoreboard whenever the DUT retires a uop
  always @(negedge CLK) begin
    if (eip_we) begin
      checkOutput("commitQueued", 32'(scoreQ.size() > 0), 32'd1);
      if (scoreQ.size() > 0) begin
        mon = scoreQ.pop_front();
        checkOutput("gprWe", 32'(gpr_we), 32'(mon.gprWe));
        checkOutput("gprAddr1", 32'(gpr_addr[2:0]), 32'(mon.dr1));
        checkOutput("gprDataA", gpr_data[31:0], mon.resA);
        checkOutput("eipOut", eip_out, mon.eip);
        checkOutput("terminate", 32'(wb_repne_terminate_all), 32'(mon.term));
        checkOutput("countFwd", count_dataforwarded, mon.cnt);
        checkOutput("flagsFwd", flags_dataforwarded, mon.flg);
      end
    end else begin
      checkOutput("termIdle", 32'(wb_repne_terminate_all), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    CLR = 1'b0;
    WB_ld_latches = 1'b0;
    dcache_wr_ack = 1'b0;
    clearInputs();
    repeat (3) @(posedge CLK);
    #3 CLR = 1'b1;
    @(posedge CLK);
    #1;

    // Reset state with nothing loaded
    checkOutput("rstGprWe", 32'(gpr_we), 32'd0);
    checkOutput("rstFlags", flags_dataforwarded, 32'h2);
    checkOutput("rstCount", count_dataforwarded, 32'h0);
    checkOutput("rstStall", 32'(WB_stall), 32'd0);
    checkOutput("rstReq", 32'(dcache_wr_req), 32'd0);
    checkOutput("rstWe", 32'({seg_we, mm_we, eip_we}), 32'd0);
    WB_ld_latches = 1'b1;

    // Directed uops: ECX load, flags load, REPNE termination variants
    applyStimulus(1, 0, 0, 0, 0, 3'd1, 2'b10, 32'h55,   32'h0, 32'h0,   32'h100);
    applyStimulus(0, 1, 0, 1, 0, 3'd4, 2'b10, 32'h66,   32'h0, 32'h846, 32'h104);
    applyStimulus(0, 0, 0, 0, 1, 3'd0, 2'b10, 32'h0,    32'h0, 32'h0,   32'h108);
    applyStimulus(1, 0, 0, 0, 0, 3'd2, 2'b10, 32'hBAD,  32'h0, 32'h0,   32'h10C);
    applyStimulus(0, 0, 0, 0, 1, 3'd0, 2'b10, 32'h0,    32'h5, 32'h40,  32'h110);
    applyStimulus(1, 0, 0, 0, 0, 3'd1, 2'b10, 32'hBAD2, 32'h0, 32'h0,   32'h114);
    applyStimulus(0, 0, 1, 0, 1, 3'd0, 2'b10, 32'h0,    32'h5, 32'h0,   32'h118);
    applyStimulus(1, 0, 0, 0, 0, 3'd1, 2'b01, 32'h77,   32'h0, 32'h0,   32'h11C);
    applyStimulus(1, 0, 0, 0, 0, 3'd1, 2'b10, 32'h1234, 32'h0, 32'h0,   32'h120);
    idleCycles(2);

    // Random back-to-back uops
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 2)),
                    2'($urandom_range(0, 2)), $urandom, 32'($urandom_range(0, 3)),
                    32'($urandom & 32'hFFF), 32'h200 + 32'(i * 4));
    end
    idleCycles(2);

    // Store with ack held low for three cycles
    driveStore(32'h1000, 32'hCAFE0001, 32'h300, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("stReqWait", 32'(dcache_wr_req), 32'd1);
      checkOutput("stStallWait", 32'(WB_stall), 32'd1);
      checkOutput("stAddr", dcache_wr_addr, 32'h1000);
      checkOutput("stData", dcache_wr_data, 32'hCAFE0001);
      checkOutput("stSegWait", 32'(seg_we), 32'd0);
      @(posedge CLK);
      #1;
    end
    dcache_wr_ack = 1'b1;
    checkOutput("stReqAck", 32'(dcache_wr_req), 32'd1);
    @(posedge CLK);
    #1;
    dcache_wr_ack = 1'b0;
    checkOutput("stReqDone", 32'(dcache_wr_req), 32'd0);
    checkOutput("stStallDone", 32'(WB_stall), 32'd0);
    checkOutput("stSegDone", 32'(seg_we), 32'd1);
    checkOutput("stEipDone", 32'(eip_we), 32'd1);
    @(posedge CLK);
    #1;
    checkOutput("stReqIdle", 32'(dcache_wr_req), 32'd0);
    checkOutput("stStallIdle", 32'(WB_stall), 32'd0);
    idleCycles(1);

    // Store acked in its first cycle commits without stalling
    dcache_wr_ack = 1'b1;
    driveStore(32'h2000, 32'hBEEF, 32'h400, 1'b1);
    checkOutput("fastReq", 32'(dcache_wr_req), 32'd1);
    checkOutput("fastStall", 32'(WB_stall), 32'd0);
    checkOutput("fastAddr", dcache_wr_addr, 32'h2000);
    checkOutput("fastEip", 32'(eip_we), 32'd1);
    @(posedge CLK);
    #1;
    dcache_wr_ack = 1'b0;
    checkOutput("fastReqAfter", 32'(dcache_wr_req), 32'd0);
    idleCycles(1);

    // Reset asserted while the store waits for its ack
    driveStore(32'h3000, 32'h1111, 32'h500, 1'b0);
    checkOutput("rsReqIdle", 32'(dcache_wr_req), 32'd1);
    @(posedge CLK);
    #1;
    checkOutput("rsReqWait", 32'(dcache_wr_req), 32'd1);
    checkOutput("rsStallWait", 32'(WB_stall), 32'd1);
    #2 CLR = 1'b0;
    #1;
    checkOutput("rsReqAsync", 32'(dcache_wr_req), 32'd0);
    checkOutput("rsStallAsync", 32'(WB_stall), 32'd0);
    checkOutput("rsFlagsAsync", flags_dataforwarded, 32'h2);
    modelFlags = 32'h2;
    modelCount = 32'h0;
    @(posedge CLK);
    #3 CLR = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      checkOutput("rsNoReissue", 32'(dcache_wr_req), 32'd0);
      checkOutput("rsNoStall", 32'(WB_stall), 32'd0);
    end

    // Normal operation resumes after reset
    applyStimulus(1, 0, 0, 0, 0, 3'd1, 2'b10, 32'h99, 32'h0, 32'h0, 32'h600);
    idleCycles(3);
    checkOutput("queueDrained", 32'(scoreQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
